// File: rtl/pterm_cmd_parser.sv
// rtl/pterm_cmd_parser.sv - line parser turning "<letter>[ <decimal>]<CR>" into one-hot opcode + 8-bit operand.
// Optional PTERM_CASE_FOLD_EN: lowercase command letters map onto the uppercase opcode bits.
module pterm_cmd_parser #(
  parameter int          OP_W     = 11,
  parameter logic [7:0]  CMD_TERM = 8'h0D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [OP_W-1:0] op_code,
  output logic [7:0]      a,
  output logic            cmd_valid,
  output logic            cmd_error
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_TAIL, S_ERR} state_t;

  localparam logic [7:0] OP_W8 = 8'(OP_W);

  state_t          state, state_nxt;
  logic [4:0]      idx, idx_nxt;
  logic [9:0]      acc, acc_nxt;
  logic [1:0]      nd, nd_nxt;
  logic [OP_W-1:0] op_nxt;
  logic [7:0]      a_nxt;
  logic            valid_nxt, error_nxt, accept;

  logic [7:0] up_off;
  logic       is_upper, is_lower, is_letter;
  logic [4:0] letter_idx;
  logic       is_digit, is_space, is_lf, is_term;
  logic [3:0] dig;
  logic [9:0] acc_step;

  assign up_off   = rx_data - 8'h41;
  assign is_upper = (rx_data >= 8'h41) && (up_off < OP_W8);

`ifdef PTERM_CASE_FOLD_EN
  logic [7:0] lo_off;
  assign lo_off     = rx_data - 8'h61;
  assign is_lower   = (rx_data >= 8'h61) && (lo_off < OP_W8);
  assign letter_idx = is_upper ? up_off[4:0] : lo_off[4:0];
`else
  assign is_lower   = 1'b0;
  assign letter_idx = up_off[4:0];
`endif

  assign is_letter = is_upper || is_lower;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign dig       = rx_data[3:0];
  assign is_space  = (rx_data == 8'h20);
  assign is_lf     = (rx_data == 8'h0A);
  assign is_term   = (rx_data == CMD_TERM);
  // Only reached with nd<3, so acc<=99 and the product cannot wrap 10 bits.
  assign acc_step  = acc * 10'd10 + {6'b0, dig};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_nxt   = acc;
    nd_nxt    = nd;
    op_nxt    = op_code;
    a_nxt     = a;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;
    accept    = 1'b0;
    // LF is transparent everywhere except inside a line already being discarded.
    if (rx_valid && (state == S_ERR || !is_lf)) begin
      case (state)
        S_IDLE: begin
          if (is_letter) begin
            idx_nxt   = letter_idx;
            acc_nxt   = '0;
            nd_nxt    = '0;
            state_nxt = S_CMD;
          end else if (!(is_space || is_term)) begin
            state_nxt = S_ERR;
          end
        end
        S_CMD: begin
          if (is_digit) begin
            acc_nxt   = {6'b0, dig};
            nd_nxt    = 2'd1;
            state_nxt = S_ARG;
          end else if (is_term) begin
            accept    = 1'b1;
            state_nxt = S_IDLE;
          end else if (!is_space) begin
            state_nxt = S_ERR;
          end
        end
        S_ARG: begin
          if (is_digit) begin
            if (nd == 2'd3 || acc_step > 10'd255) begin
              state_nxt = S_ERR;
            end else begin
              acc_nxt = acc_step;
              nd_nxt  = nd + 2'd1;
            end
          end else if (is_space) begin
            state_nxt = S_TAIL;
          end else if (is_term) begin
            accept    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_ERR;
          end
        end
        S_TAIL: begin
          if (is_term) begin
            accept    = 1'b1;
            state_nxt = S_IDLE;
          end else if (!is_space) begin
            state_nxt = S_ERR;
          end
        end
        S_ERR: begin
          if (is_term) begin
            error_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (accept) begin
      op_nxt    = OP_W'(1) << idx;
      a_nxt     = acc[7:0];
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      nd        <= '0;
      op_code   <= '0;
      a         <= '0;
      cmd_valid <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      acc       <= acc_nxt;
      nd        <= nd_nxt;
      op_code   <= op_nxt;
      a         <= a_nxt;
      cmd_valid <= valid_nxt;
      cmd_error <= error_nxt;
    end
  end

endmodule

// File: tb/tb_pterm_cmd_parser.sv
// tb/tb_pterm_cmd_parser.sv - directed vector table plus gapped-input sequence for pterm_cmd_parser.
module tb_pterm_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [10:0] op_code;
  logic [7:0]  a;
  logic        cmd_valid;
  logic        cmd_error;

  int tests  = 0;
  int failed = 0;

  pterm_cmd_parser dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .op_code  (op_code),
    .a        (a),
    .cmd_valid(cmd_valid),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        rst;
    logic        ev;
    logic        ee;
    logic [10:0] eop;
    logic [7:0]  ea;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [7:0] d, input logic v, input logic r,
                              input logic ev, input logic ee,
                              input logic [10:0] eop, input logic [7:0] ea);
    vec_t t;
    t.data = d; t.valid = v; t.rst = r; t.ev = ev; t.ee = ee; t.eop = eop; t.ea = ea;
    vq.push_back(t);
  endfunction

  // '^' stands for CR and '|' for LF; outputs hold op0/a0 until the last byte yields op1/a1.
  function automatic void push_line(input string s, input logic ev, input logic ee,
                                    input logic [10:0] op0, input logic [7:0] a0,
                                    input logic [10:0] op1, input logic [7:0] a1);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "^") c = 8'h0D;
      if (c == "|") c = 8'h0A;
      if (i == s.len() - 1) add(c, 1'b1, 1'b0, ev, ee, op1, a1);
      else                  add(c, 1'b1, 1'b0, 1'b0, 1'b0, op0, a0);
    end
  endfunction

  task automatic check(input string name, input logic ev, input logic ee,
                       input logic [10:0] eop, input logic [7:0] ea);
    tests++;
    if (cmd_valid !== ev || cmd_error !== ee || op_code !== eop || a !== ea) begin
      failed++;
      $display("FAIL %s: got cv=%0b ce=%0b op=%b a=%0d, expected cv=%0b ce=%0b op=%b a=%0d",
               name, cmd_valid, cmd_error, op_code, a, ev, ee, eop, ea);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic r);
    rx_data = d; rx_valid = v; rst = r;
    @(posedge clk);
    #1;
  endtask

  logic [10:0] f_op;
  logic [7:0]  f_a;
  logic        f_ev, f_ee;

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

`ifdef PTERM_CASE_FOLD_EN
    f_op = 11'b00000100000; f_a = 8'd3; f_ev = 1'b1; f_ee = 1'b0;
`else
    f_op = 11'b0;           f_a = 8'd0; f_ev = 1'b0; f_ee = 1'b1;
`endif

    add(8'h00, 1'b0, 1'b1, 0, 0, 11'b0, 8'd0);
    push_line("F 42^",    1, 0, 11'b0,           8'd0,   11'b00000100000, 8'd42);
    add(8'h00, 1'b0, 1'b0, 0, 0, 11'b00000100000, 8'd42);
    push_line("A^",       1, 0, 11'b00000100000, 8'd42,  11'b00000000001, 8'd0);
    push_line("K  255 ^", 1, 0, 11'b00000000001, 8'd0,   11'b10000000000, 8'd255);
    push_line("B 256^",   0, 1, 11'b10000000000, 8'd255, 11'b10000000000, 8'd255);
    push_line("C 1234^",  0, 1, 11'b10000000000, 8'd255, 11'b10000000000, 8'd255);
    push_line("Z^",       0, 1, 11'b10000000000, 8'd255, 11'b10000000000, 8'd255);
    push_line("^|^",      0, 0, 11'b10000000000, 8'd255, 11'b10000000000, 8'd255);
    push_line("G 007^",   1, 0, 11'b10000000000, 8'd255, 11'b00001000000, 8'd7);
    push_line("H 0007^",  0, 1, 11'b00001000000, 8'd7,   11'b00001000000, 8'd7);
    push_line("J|5|^",    1, 0, 11'b00001000000, 8'd7,   11'b01000000000, 8'd5);
    push_line("I 9 x^",   0, 1, 11'b01000000000, 8'd5,   11'b01000000000, 8'd5);
    push_line("@|^",      0, 1, 11'b01000000000, 8'd5,   11'b01000000000, 8'd5);
    push_line("E 12",     0, 0, 11'b01000000000, 8'd5,   11'b01000000000, 8'd5);
    add(8'h00, 1'b0, 1'b1, 0, 0, 11'b0, 8'd0);
    push_line("^",        0, 0, 11'b0,           8'd0,   11'b0,           8'd0);
    push_line("f 3^",     f_ev, f_ee, 11'b0,     8'd0,   f_op,            f_a);
    push_line("A 5",      0, 0, f_op,            f_a,    f_op,            f_a);
    add(8'h0D, 1'b1, 1'b1, 0, 0, 11'b0, 8'd0);
    add(8'h00, 1'b0, 1'b0, 0, 0, 11'b0, 8'd0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].data, vq[i].valid, vq[i].rst);
      check($sformatf("vec%0d", i), vq[i].ev, vq[i].ee, vq[i].eop, vq[i].ea);
    end

    // "D", gap, "7", gap, CR with random idle gaps in between
    drive("D", 1'b1, 1'b0);
    check("gap_d", 0, 0, 11'b0, 8'd0);
    for (int g = $urandom_range(1, 5); g > 0; g--) begin
      drive(8'h0D, 1'b0, 1'b0);
      check("gap_idle1", 0, 0, 11'b0, 8'd0);
    end
    drive("7", 1'b1, 1'b0);
    check("gap_7", 0, 0, 11'b0, 8'd0);
    for (int g = $urandom_range(1, 5); g > 0; g--) begin
      drive(8'h0D, 1'b0, 1'b0);
      check("gap_idle2", 0, 0, 11'b0, 8'd0);
    end
    drive(8'h0D, 1'b1, 1'b0);
    check("gap_cr", 1, 0, 11'b00000001000, 8'd7);
    drive(8'h00, 1'b0, 1'b0);
    check("gap_hold", 0, 0, 11'b00000001000, 8'd7);

    // next line's first byte right after the terminator
    drive("B", 1'b1, 1'b0);
    drive(8'h0D, 1'b1, 1'b0);
    check("b2b_1", 1, 0, 11'b00000000010, 8'd0);
    drive("C", 1'b1, 1'b0);
    check("b2b_pulse_end", 0, 0, 11'b00000000010, 8'd0);
    drive(8'h0D, 1'b1, 1'b0);
    check("b2b_2", 1, 0, 11'b00000000100, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
